// File: rtl/edge_event_arbiter.sv
// Rising-edge event scheduler: latches per-line edges as pending events and
// offers them one at a time on a valid/ready port in round-robin order.
module edge_event_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in,
  input  logic            evt_ready,
  input  logic            ovr_clr,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overrun
);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_prev, r_pending, r_overrun;
  logic [N-1:0]    w_rise, w_acc_vec, w_pend_masked;
  logic [ID_W-1:0] r_id, r_ptr, w_id_nxt, w_ptr_nxt;
  logic [ID_W:0]   w_pick;
  logic            w_acc;

  function automatic logic [ID_W-1:0] next_ch(input logic [ID_W-1:0] ch);
    return (ch == ID_W'(N - 1)) ? '0 : ch + 1'b1;
  endfunction

  // Returns {found, id}: first requesting channel at or after start, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [N-1:0]    req,
                                            input logic [ID_W-1:0] start);
    logic            found;
    logic [ID_W-1:0] id;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    id    = '0;
    idx   = start;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        id    = idx;
      end
      idx = next_ch(idx);
    end
    return {found, id};
  endfunction

  assign w_rise        = in & ~r_prev;
  assign w_acc         = (r_state == S_OFFER) && evt_ready;
  assign w_acc_vec     = w_acc ? (N'(1) << r_id) : '0;
  assign w_pend_masked = r_pending & ~w_acc_vec;
  // In IDLE nothing is masked and ptr is unchanged, so one search serves both states.
  assign w_ptr_nxt     = w_acc ? next_ch(r_id) : r_ptr;
  assign w_pick        = rr_pick(w_pend_masked, w_ptr_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      S_IDLE: begin
        if (w_pick[ID_W]) begin
          w_state_nxt = S_OFFER;
          w_id_nxt    = w_pick[ID_W-1:0];
        end
      end
      S_OFFER: begin
        if (w_acc) begin
          if (w_pick[ID_W]) w_id_nxt = w_pick[ID_W-1:0];
          else              w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_pend_masked | w_rise;
      r_overrun <= (ovr_clr ? '0 : r_overrun) | (w_rise & w_pend_masked);
    end
  end

  // Tracks the line during reset too, so a level held across release is not an edge.
  always_ff @(posedge clk) begin
    r_prev <= in;
  end

  assign evt_valid = (r_state == S_OFFER);
  assign evt_id    = r_id;
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed vector table plus randomized traffic
// checked against an event-level reference model.
module tb_edge_event_arbiter;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_v = '0;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic [3:0] overrun;

  int n_checks = 0;
  int n_errors = 0;

  edge_event_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_v),
    .evt_ready (rdy),
    .ovr_clr   (clr),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] in_v;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovr;
    logic [1:0] ptr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] i, input logic rd,
                              input logic c, input logic v, input logic [1:0] id,
                              input logic [3:0] p, input logic [3:0] o,
                              input logic [1:0] pt);
    vec_t e;
    e.rst_n = r; e.in_v = i; e.rdy = rd; e.clr = c;
    e.v = v; e.id = id; e.pend = p; e.ovr = o; e.ptr = pt;
    vecs.push_back(e);
  endfunction

  // Reference model: per-channel event flags and a priority pointer.
  int m_prev[N];
  int m_pend[N];
  int m_ovr[N];
  int m_valid;
  int m_id;
  int m_ptr;

  function automatic void model_step();
    int acc_ch, cand, c, rise, keep;
    int n_pend[N];
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_ovr[i] = 0; m_prev[i] = int'(in_v[i]);
      end
      m_valid = 0; m_id = 0; m_ptr = 0;
      return;
    end
    acc_ch = (m_valid != 0 && rdy) ? m_id : -1;
    for (int i = 0; i < N; i++) begin
      rise      = (in_v[i] && m_prev[i] == 0) ? 1 : 0;
      keep      = (m_pend[i] != 0 && i != acc_ch) ? 1 : 0;
      n_pend[i] = (rise != 0 || keep != 0) ? 1 : 0;
      m_ovr[i]  = ((rise != 0 && keep != 0) || (m_ovr[i] != 0 && !clr)) ? 1 : 0;
    end
    if (acc_ch >= 0) m_ptr = (acc_ch + 1) % N;
    if (m_valid == 0 || acc_ch >= 0) begin
      cand = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (cand < 0 && m_pend[c] != 0 && c != acc_ch) cand = c;
      end
      if (cand >= 0) begin m_valid = 1; m_id = cand; end
      else m_valid = 0;
    end
    for (int i = 0; i < N; i++) begin
      m_pend[i] = n_pend[i];
      m_prev[i] = int'(in_v[i]);
    end
  endfunction

  function automatic logic [3:0] pack4(input int a[N]);
    logic [3:0] r;
    for (int i = 0; i < N; i++) r[i] = (a[i] != 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " valid"},   32'(evt_valid), 32'(m_valid));
    if (m_valid != 0) chk({tag, " id"}, 32'(evt_id), 32'(m_id));
    chk({tag, " pending"}, 32'(pending), 32'(pack4(m_pend)));
    chk({tag, " overrun"}, 32'(overrun), 32'(pack4(m_ovr)));
    chk({tag, " ptr"},     32'(dut.r_ptr), 32'(m_ptr));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin m_prev[i] = 0; m_pend[i] = 0; m_ovr[i] = 0; end
    m_valid = 0; m_id = 0; m_ptr = 0;

    // reset with 0101 held high across release
    add(0, 4'b0101, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0101, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 10; k++) add(1, 4'b0101, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // single pulse on in[2]
    add(1, 4'b0100, 1, 0, 0, 0, 4'b0100, 4'b0000, 0);
    add(1, 4'b0000, 1, 0, 1, 2, 4'b0100, 4'b0000, 0);
    add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 3);
    add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 3);
    // reset, then all four channels at once
    add(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b1111, 1, 0, 0, 0, 4'b1111, 4'b0000, 0);
    add(1, 4'b0000, 1, 0, 1, 0, 4'b1111, 4'b0000, 0);
    add(1, 4'b0000, 1, 0, 1, 1, 4'b1110, 4'b0000, 1);
    add(1, 4'b0000, 1, 0, 1, 2, 4'b1100, 4'b0000, 2);
    add(1, 4'b0000, 1, 0, 1, 3, 4'b1000, 4'b0000, 3);
    add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    // backpressure, overrun on ch1, then drain and clear
    add(1, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000, 0);
    add(1, 4'b0000, 0, 0, 1, 1, 4'b0010, 4'b0000, 0);
    add(1, 4'b1000, 0, 0, 1, 1, 4'b1010, 4'b0000, 0);
    add(1, 4'b0010, 0, 0, 1, 1, 4'b1010, 4'b0010, 0);
    add(1, 4'b0000, 0, 0, 1, 1, 4'b1010, 4'b0010, 0);
    add(1, 4'b0000, 1, 0, 1, 3, 4'b1000, 4'b0010, 2);
    add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0010, 0);
    add(1, 4'b0000, 0, 1, 0, 0, 4'b0000, 4'b0000, 0);
    // same-cycle rise and acceptance on ch0
    add(1, 4'b0011, 0, 0, 0, 0, 4'b0011, 4'b0000, 0);
    add(1, 4'b0000, 0, 0, 1, 0, 4'b0011, 4'b0000, 0);
    add(1, 4'b0001, 1, 0, 1, 1, 4'b0011, 4'b0000, 1);
    add(1, 4'b0000, 1, 0, 1, 0, 4'b0001, 4'b0000, 2);
    add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 1);
    // overrun set coinciding with clear: set wins
    add(1, 4'b0100, 0, 0, 0, 0, 4'b0100, 4'b0000, 1);
    add(1, 4'b0000, 0, 0, 1, 2, 4'b0100, 4'b0000, 1);
    add(1, 4'b0100, 0, 1, 1, 2, 4'b0100, 4'b0100, 1);
    add(1, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000, 3);
    // reset while offering with three pending
    add(1, 4'b0111, 0, 0, 0, 0, 4'b0111, 4'b0000, 3);
    add(1, 4'b0000, 0, 0, 1, 0, 4'b0111, 4'b0000, 3);
    add(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 3; k++) add(1, 4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);

    for (int j = 0; j < vecs.size(); j++) begin
      rst = vecs[j].rst_n; in_v = vecs[j].in_v; rdy = vecs[j].rdy; clr = vecs[j].clr;
      tick();
      chk($sformatf("vec%0d valid", j), 32'(evt_valid), 32'(vecs[j].v));
      if (vecs[j].v) chk($sformatf("vec%0d id", j), 32'(evt_id), 32'(vecs[j].id));
      chk($sformatf("vec%0d pending", j), 32'(pending), 32'(vecs[j].pend));
      chk($sformatf("vec%0d overrun", j), 32'(overrun), 32'(vecs[j].ovr));
      chk($sformatf("vec%0d ptr", j), 32'(dut.r_ptr), 32'(vecs[j].ptr));
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 199) != 0);
      in_v = 4'($urandom);
      rdy  = ($urandom_range(0, 9) < 6);
      clr  = ($urandom_range(0, 19) == 0);
      tick();
      chk_model($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel rising-edge event scheduler. It detects rising edges on N synchronous input lines and latches each edge as a pending event. It then shares a single event output port between the channels using round-robin arbitration and a valid/ready handshake. It sits between the per-line edge detection front end and the single event consumer, such as an interrupt or logging block.

## Interface
- N, default 4: number of input channels (2..16).
- ID_W, default $clog2(N): width of the channel index; derived, not overridden.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- in  input  N  event lines; already synchronous to clk.
- evt_ready  input  1  consumer accepts the offered event this cycle.
- ovr_clr  input  1  one-cycle pulse; clears all overrun flags.
- evt_valid  output  1  an event is offered on evt_id.
- evt_id  output  ID_W  channel index of the offered event.
- pending  output  N  per-channel latched, not-yet-accepted events.
- overrun  output  N  sticky per-channel flag for a lost edge.

## Operation
- Edge detect: prev[i] registers in[i] every cycle, and rise[i] = in[i] & ~prev[i].
- While rst=0, prev loads in. A line held high across reset release produces no event.
- Pending latch:
  - rise[i] sets pending[i].
  - Acceptance of channel i (evt_valid & evt_ready & evt_id==i) clears pending[i].
  - Rise and acceptance on the same channel in the same cycle: pending[i] stays 1 (new event), no overrun.
- Overrun:
  - rise[i] while pending[i]=1 and channel i is not being accepted sets overrun[i]. The edge is merged, not queued.
  - ovr_clr clears all flags.
  - If ovr_clr coincides with a new overrun on channel i, overrun[i] ends at 1 (set wins).
- FSM with two states, IDLE and OFFER.
  - IDLE, evt_valid=0: if pending is nonzero, load evt_id with the round-robin winner and go to OFFER. Otherwise stay.
  - OFFER, evt_valid=1: hold evt_id stable until evt_ready=1.
  - On acceptance, compute the winner over pending with the accepted bit masked:
    - If any remains, stay in OFFER and load the new evt_id (back-to-back offers, no bubble).
    - Else go to IDLE.
  - Without evt_ready, evt_valid and evt_id never change. Edges arriving meanwhile only update pending and overrun.
- Round-robin:
  - ptr (ID_W bits) is the highest-priority channel.
  - Search order is ptr, ptr+1, ..., wrapping modulo N.
  - On acceptance of channel g, ptr <= (g+1) mod N. For N not a power of two, wrap from N-1 to 0 explicitly.
  - ptr changes only on acceptance.
- Winner selection uses the registered pending value. An edge detected in the same cycle competes from the next cycle.

## Timing
- Reset values: evt_valid=0, evt_id=0, pending=0, overrun=0, ptr=0, FSM=IDLE.
- Edge latency:
  - in[i] is 0 at edge k-1 and 1 at edge k.
  - pending[i]=1 after edge k.
  - evt_valid=1 with evt_id=i after edge k+1, when the FSM was IDLE with no other pending channel.
- Acceptance takes effect at the edge where evt_valid & evt_ready is sampled high. pending clears and the next offer appears after that same edge.
- Throughput: one event per cycle while evt_ready is held high and events remain pending.
- evt_ready while evt_valid=0 is ignored.
- rst=0 mid-offer: outputs return to reset values at the next edge. Pending events are discarded and no acceptance is reported.
- All outputs are registered; there is no combinational path from in or evt_ready to any output.

## Test plan
- Reset release with in=4'b0101 held high: no rise, no event, evt_valid stays 0 for 10 cycles.
- Single pulse on in[2] with evt_ready=1:
  - pending=4'b0100 one cycle after the edge.
  - evt_valid=1 with evt_id=2 the cycle after that, for exactly one cycle.
  - Then pending=0 and ptr=3.
- Simultaneous pulses on in[3:0]=4'b1111 from ptr=0, evt_ready=1:
  - evt_id sequence 0,1,2,3 on consecutive cycles, evt_valid high for 4 cycles.
  - Then ptr=0.
- Backpressure:
  - evt_ready=0, edges on channels 1 then 3, then a second edge on channel 1.
  - evt_id holds 1 stable and overrun=4'b0010.
  - With evt_ready=1: ids 1 then 3, then evt_valid=0.
  - ovr_clr then gives overrun=0.
- Same-cycle rise and acceptance on channel 0:
  - pending[0] stays 1 and overrun[0] stays 0.
  - Channel 0 is re-offered after any other pending channels, per round-robin.
- rst=0 asserted while evt_valid=1 with 3 channels pending: next cycle evt_valid=0, pending=0, ptr=0, and no event is offered after reset release.
